alu_issue_unit: RTL
===================

Name: alu_issue_unit

Overview:
- Upstream/downstream companion of the ALU.
- Accepts MIPS R-type instructions over a valid/ready handshake and reads operands from an internal 32-entry register file.
- Drives the ALU operand/select inputs, captures the ALU result and zero flag, and writes the result back to the destination register.
- Serialized 4-state controller, one instruction in flight; no hazards by construction.

Parameters:
- word_size, 32, datapath and register width
- op_size, 3, ALU select width
- reg_addr_size, 5, register index width (2**reg_addr_size entries)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- instr_valid  input  1  instruction present on instr
- instr  input  word_size  R-type instruction: rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]
- instr_ready  output  1  unit can accept an instruction
- alu_data_1  output  word_size  ALU operand A (rs value)
- alu_data_2  output  word_size  ALU operand B (rt value)
- alu_sel  output  op_size  ALU operation select
- alu_out  input  word_size  ALU combinational result
- alu_zero_flag  input  1  ALU zero flag
- done  output  1  one-cycle pulse: instruction retired
- illegal  output  1  one-cycle pulse, coincident with done: unsupported opcode/funct
- result  output  word_size  last captured ALU result (held)
- zero  output  1  last captured zero flag (held)
- dbg_addr  input  reg_addr_size  debug register index
- dbg_data  output  word_size  combinational register file read of dbg_addr (0 for index 0)

Behaviour:
- States: IDLE, READ, EXEC, WB. Encoding is free.
- Reset (synchronous, priority over everything):
  - state=IDLE; all registers cleared to 0.
  - alu_data_1/alu_data_2/alu_sel/result/zero = 0; done = illegal = 0; instr_ready = 1 on the first cycle after reset.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, latch instr fields and go to READ.
  - instr is ignored when instr_valid=0.
- READ:
  - Latch regs[rs] into alu_data_1 and regs[rt] into alu_data_2.
  - Decode funct to alu_sel: 0x20 ADD->0, 0x22 SUB->1, 0x24 AND->2, 0x25 OR->3, 0x26 XOR->4, 0x27 NOR->5, 0x2A SLT->6.
  - instr[31:26]!=0 or any other funct sets the illegal flag; alu_sel=0 in that case.
  - Go to EXEC.
- EXEC: operands stable for a full cycle so the ALU settles; go to WB.
- WB:
  - Capture alu_out into result and alu_zero_flag into zero.
  - Write regs[rd]=alu_out unless rd==0 or illegal.
  - done=1 for this cycle; illegal=1 if flagged. Go to IDLE.
- instr_ready=0 in READ, EXEC and WB.
- Latency: accept at edge T, done high during cycle T+3, written value visible on dbg_data from cycle T+4.
- Throughput: next accept no earlier than T+4 (one instruction per 4 cycles).
- Register 0: always reads 0; writes to it are discarded.
- Operand/select outputs hold their last values in IDLE; no glitching between instructions.
- Reset mid-operation (READ/EXEC/WB): abandon the instruction, no writeback, no done pulse.
- rs==rd or rt==rd: operands are read in READ before the WB write, so old values are used.
- Arithmetic is performed entirely by the ALU; this unit does no width extension. Result width is word_size; overflow is not detected.

Test Plan:
- Reset, then hold instr_valid=0 for 10 cycles -> instr_ready=1, done never pulses, dbg_data=0 for every dbg_addr.
- No instructions issued, so all registers read 0. ADD r1=r0+r0 then SUB r2=r1-r0 -> done at T+3 each, result=0, zero=1, dbg_data(r1)=0. Next, seed via ADD chain with ALU model giving 5 -> regs[3]=5 on dbg_data at T+4.
- With r4=7 and r5=7: SUB r6,r4,r5 -> alu_sel=1, alu_data_1=7, alu_data_2=7, result=0, zero=1. SLT r7,r5,r4 -> alu_sel=6, result=0.
- ADD rd=0 with nonzero operands -> done=1, result nonzero, dbg_data(0)=0.
- funct=0x08 and opcode=0x23 -> illegal=1 with done, no register changes, instr_ready back to 1 at T+4.
- Assert rst during EXEC of ADD r8 -> next cycle state IDLE, instr_ready=1, no done, dbg_data(8)=0. Also hold instr_valid=1 continuously -> accepts exactly every 4 cycles.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue/writeback controller for an external combinational ALU.
// Runs one MIPS R-type instruction at a time through IDLE -> READ -> EXEC -> WB.
module alu_issue_unit #(
   parameter int word_size     = 32,
   parameter int op_size       = 3,
   parameter int reg_addr_size = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   input  logic [word_size-1:0]     instr,
   output logic                     instr_ready,
   output logic [word_size-1:0]     alu_data_1,
   output logic [word_size-1:0]     alu_data_2,
   output logic [op_size-1:0]       alu_sel,
   input  logic [word_size-1:0]     alu_out,
   input  logic                     alu_zero_flag,
   output logic                     done,
   output logic                     illegal,
   output logic [word_size-1:0]     result,
   output logic                     zero,
   input  logic [reg_addr_size-1:0] dbg_addr,
   output logic [word_size-1:0]     dbg_data
);

   localparam int num_regs = 2 ** reg_addr_size;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   state_t state_reg, state_next;

   logic [reg_addr_size-1:0] rs_reg, rt_reg, rd_reg;
   logic [5:0]               funct_reg, opcode_reg;
   logic                     illegal_reg;
   logic [word_size-1:0]     alu_data_1_reg, alu_data_2_reg;
   logic [op_size-1:0]       alu_sel_reg;
   logic [word_size-1:0]     result_reg;
   logic                     zero_reg;
   logic [word_size-1:0]     regs [num_regs];

   logic [op_size-1:0]       sel_dec;
   logic                     illegal_dec;

   // shamt is not used by any supported operation
   logic unused_shamt;
   assign unused_shamt = ^instr[10:6];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
      case (state_reg)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_next = READ;
            end
         end
         READ: state_next = EXEC;
         EXEC: state_next = WB;
         WB: begin
            done       = 1'b1;
            illegal    = illegal_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sel_dec     = '0;
      illegal_dec = 1'b0;
      case (funct_reg)
         6'h20:   sel_dec = op_size'(0);
         6'h22:   sel_dec = op_size'(1);
         6'h24:   sel_dec = op_size'(2);
         6'h25:   sel_dec = op_size'(3);
         6'h26:   sel_dec = op_size'(4);
         6'h27:   sel_dec = op_size'(5);
         6'h2A:   sel_dec = op_size'(6);
         default: illegal_dec = 1'b1;
      endcase
      if (opcode_reg != 6'd0) begin
         illegal_dec = 1'b1;
      end
      if (illegal_dec) begin
         sel_dec = '0;
      end
   end

   // Entry 0 is never written, so reading regs[0] always yields zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs_reg         <= '0;
         rt_reg         <= '0;
         rd_reg         <= '0;
         funct_reg      <= '0;
         opcode_reg     <= '0;
         illegal_reg    <= 1'b0;
         alu_data_1_reg <= '0;
         alu_data_2_reg <= '0;
         alu_sel_reg    <= '0;
         result_reg     <= '0;
         zero_reg       <= 1'b0;
         for (int i = 0; i < num_regs; i++) begin
            regs[i] <= '0;
         end
      end else begin
         if (state_reg == IDLE && instr_valid) begin
            opcode_reg <= instr[31:26];
            rs_reg     <= instr[25:21];
            rt_reg     <= instr[20:16];
            rd_reg     <= instr[15:11];
            funct_reg  <= instr[5:0];
         end
         if (state_reg == READ) begin
            alu_data_1_reg <= regs[rs_reg];
            alu_data_2_reg <= regs[rt_reg];
            alu_sel_reg    <= sel_dec;
            illegal_reg    <= illegal_dec;
         end
         if (state_reg == WB) begin
            result_reg <= alu_out;
            zero_reg   <= alu_zero_flag;
            if (!illegal_reg && rd_reg != '0) begin
               regs[rd_reg] <= alu_out;
            end
         end
      end
   end

   assign alu_data_1 = alu_data_1_reg;
   assign alu_data_2 = alu_data_2_reg;
   assign alu_sel    = alu_sel_reg;
   assign result     = result_reg;
   assign zero       = zero_reg;
   assign dbg_data   = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule
